// File: rtl/cj_test_harness.sv
// Simulation harness: tohost pass/timeout tracking, marker-instruction event decode and an
// optional coverage-stall/watchdog interrupt, enabled by defining COVERAGE_SUMMARY_EN.
module cj_test_harness #(
  parameter logic [31:0] TOHOST_ADDR    = 32'h8000_1000,
  parameter logic [63:0] MAX_CYCLES     = 64'd2_000_000_000,
  parameter int unsigned MAX_WAIT_CYCLE = 1000,
  parameter int unsigned WATCHDOG_LIMIT = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [63:0] wr_data,
  input  logic        enq_valid,
  input  logic [31:0] enq_inst,
  input  logic        commit_valid,
  input  logic [31:0] commit_inst,
  input  logic [29:0] cov,
  input  logic        io_uart_rx,
  output logic        io_uart_tx,
  output logic [63:0] tohost,
  output logic        pass,
  output logic        timeout,
  output logic [63:0] cycle_count,
  output logic        enq_evt_valid,
  output logic [3:0]  enq_evt_id,
  output logic        cmt_evt_valid,
  output logic [3:0]  cmt_evt_id,
  output logic        interrupt
);

  // Markers are "slti x0,x0,k": only the immediate nibble varies, and k must be below 14.
  function automatic logic is_marker(input logic [31:0] inst);
    return (inst[31:24] == 8'h00) && (inst[19:0] == 20'h02013) && (inst[23:20] < 4'd14);
  endfunction

  logic enq_hit;
  logic cmt_hit;
  logic tohost_hit;
  logic timeout_now;

  assign enq_hit     = enq_valid && is_marker(enq_inst);
  assign cmt_hit     = commit_valid && is_marker(commit_inst);
  assign tohost_hit  = wr_en && (wr_addr == TOHOST_ADDR);
  assign timeout_now = cycle_count > MAX_CYCLES;

  assign io_uart_tx = 1'b1;
  assign pass       = tohost[0];

  always_ff @(posedge clock) begin
    if (!reset) begin
      tohost        <= '0;
      cycle_count   <= '0;
      timeout       <= 1'b0;
      enq_evt_valid <= 1'b0;
      enq_evt_id    <= '0;
      cmt_evt_valid <= 1'b0;
      cmt_evt_id    <= '0;
    end else begin
      enq_evt_valid <= enq_hit;
      if (enq_hit) enq_evt_id <= enq_inst[23:20];
      cmt_evt_valid <= cmt_hit;
      if (cmt_hit) cmt_evt_id <= commit_inst[23:20];

      // A timeout forces the failure code 5 even if software writes tohost in the same cycle.
      timeout <= timeout_now;
      if (timeout_now) tohost <= 64'd5;
      else if (tohost_hit) tohost <= wr_data;

      if (timeout_now || tohost[0]) cycle_count <= '0;
      else cycle_count <= cycle_count + 64'd1;
    end
  end

`ifdef COVERAGE_SUMMARY_EN
  logic [29:0] pre_cov;
  logic [63:0] stall;
  logic [63:0] watchdog;
  logic [31:0] stall_limit;
  logic        unused_rx;

  always_ff @(posedge clock) begin
    if (!reset) begin
      pre_cov  <= '0;
      stall    <= '0;
      watchdog <= '0;
    end else begin
      if (cov != pre_cov) pre_cov <= cov;
      if (tohost[0]) begin
        stall    <= '0;
        watchdog <= '0;
      end else begin
        if (cov != pre_cov) stall <= '0;
        else if (stall != '1) stall <= stall + 64'd1;
        if (watchdog != '1) watchdog <= watchdog + 64'd1;
      end
    end
  end

  // Higher coverage levels tolerate proportionally longer stalls.
  assign stall_limit = MAX_WAIT_CYCLE * (32'(cov >> 19) + 32'd1);
  assign interrupt   = (stall >= {32'd0, stall_limit}) || (watchdog >= 64'(WATCHDOG_LIMIT));
  assign unused_rx   = io_uart_rx;
`else
  logic unused_inputs;

  assign interrupt     = 1'b0;
  assign unused_inputs = ^{io_uart_rx, cov};
`endif

endmodule

// File: tb/tb_cj_test_harness.sv
// Bench for cj_test_harness: marker vector table, tohost/timeout sequences, stall and watchdog
// interrupt sequences, and randomized traffic checked against a cycle-level reference model.
module tb_cj_test_harness;

  localparam logic [31:0]     TOHOST_ADDR = 32'h8000_1000;
  localparam logic [63:0]     MAIN_MAX    = 64'd2_000_000_000;
  localparam longint unsigned MAX_WAIT    = 1000;
  localparam longint unsigned WD_LIMIT    = 50000;
`ifdef COVERAGE_SUMMARY_EN
  localparam logic COV_EN = 1'b1;
`else
  localparam logic COV_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  logic wr_en;
  logic [31:0] wr_addr;
  logic [63:0] wr_data;
  logic enq_valid;
  logic [31:0] enq_inst;
  logic commit_valid;
  logic [31:0] commit_inst;
  logic [29:0] cov;
  logic io_uart_rx;
  logic io_uart_tx;
  logic [63:0] tohost;
  logic pass;
  logic timeout;
  logic [63:0] cycle_count;
  logic enq_evt_valid;
  logic [3:0] enq_evt_id;
  logic cmt_evt_valid;
  logic [3:0] cmt_evt_id;
  logic interrupt;

  // Second instance with a tiny timeout threshold and quiet inputs.
  logic to_reset;
  logic zero1 = 1'b0;
  logic [31:0] zero32 = '0;
  logic [63:0] zero64 = '0;
  logic [29:0] zero30 = '0;
  logic to_uart_tx, to_pass, to_timeout, to_enq_v, to_cmt_v, to_interrupt;
  logic [63:0] to_tohost, to_cycle_count;
  logic [3:0] to_enq_id, to_cmt_id;

  always #5 clock = ~clock;

  cj_test_harness #(.TOHOST_ADDR(TOHOST_ADDR), .MAX_CYCLES(MAIN_MAX),
                    .MAX_WAIT_CYCLE(1000), .WATCHDOG_LIMIT(50000)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .enq_valid(enq_valid), .enq_inst(enq_inst), .commit_valid(commit_valid),
    .commit_inst(commit_inst), .cov(cov), .io_uart_rx(io_uart_rx), .io_uart_tx(io_uart_tx),
    .tohost(tohost), .pass(pass), .timeout(timeout), .cycle_count(cycle_count),
    .enq_evt_valid(enq_evt_valid), .enq_evt_id(enq_evt_id), .cmt_evt_valid(cmt_evt_valid),
    .cmt_evt_id(cmt_evt_id), .interrupt(interrupt)
  );

  cj_test_harness #(.TOHOST_ADDR(TOHOST_ADDR), .MAX_CYCLES(64'd10),
                    .MAX_WAIT_CYCLE(1000), .WATCHDOG_LIMIT(50000)) dut_to (
    .clock(clock), .reset(to_reset), .wr_en(zero1), .wr_addr(zero32), .wr_data(zero64),
    .enq_valid(zero1), .enq_inst(zero32), .commit_valid(zero1), .commit_inst(zero32),
    .cov(zero30), .io_uart_rx(zero1), .io_uart_tx(to_uart_tx), .tohost(to_tohost),
    .pass(to_pass), .timeout(to_timeout), .cycle_count(to_cycle_count),
    .enq_evt_valid(to_enq_v), .enq_evt_id(to_enq_id), .cmt_evt_valid(to_cmt_v),
    .cmt_evt_id(to_cmt_id), .interrupt(to_interrupt)
  );

  typedef struct {
    logic        enq_valid;
    logic [31:0] enq_inst;
    logic        commit_valid;
    logic [31:0] commit_inst;
    logic        exp_enq_v;
    logic [3:0]  exp_enq_id;
    logic        exp_cmt_v;
    logic [3:0]  exp_cmt_id;
  } vec_t;

  vec_t vecs [8];

  logic [63:0] m_tohost, m_cycle;
  logic m_timeout, m_enq_v, m_cmt_v;
  logic [3:0] m_enq_id, m_cmt_id;
  logic [29:0] m_pre_cov;
  longint unsigned m_stall, m_wd;

  int n_checks = 0;
  int n_fails  = 0;

  function automatic int marker_id(input logic [31:0] inst);
    for (int k = 0; k < 14; k++)
      if (inst == (32'h0000_2013 | (32'(k) << 20))) return k;
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  // Reference model: advances one clock edge using the inputs as they were at that edge.
  task automatic modelStep();
    logic to_now;
    int ke, kc;
    logic changed;
    if (!reset) begin
      m_tohost = '0; m_cycle = '0; m_timeout = 1'b0;
      m_enq_v = 1'b0; m_enq_id = '0; m_cmt_v = 1'b0; m_cmt_id = '0;
      m_pre_cov = '0; m_stall = 0; m_wd = 0;
      return;
    end
    ke = marker_id(enq_inst);
    kc = marker_id(commit_inst);
    m_enq_v = enq_valid && (ke >= 0);
    if (m_enq_v) m_enq_id = 4'(ke);
    m_cmt_v = commit_valid && (kc >= 0);
    if (m_cmt_v) m_cmt_id = 4'(kc);

    changed = (cov != m_pre_cov);
    m_pre_cov = cov;
    if (m_tohost[0]) begin
      m_stall = 0;
      m_wd = 0;
    end else begin
      m_stall = changed ? 0 : m_stall + 1;
      m_wd = m_wd + 1;
    end

    to_now = (m_cycle > MAIN_MAX);
    m_cycle = (to_now || m_tohost[0]) ? 64'd0 : m_cycle + 64'd1;
    m_timeout = to_now;
    if (to_now) m_tohost = 64'd5;
    else if (wr_en && wr_addr == TOHOST_ADDR) m_tohost = wr_data;
  endtask

  function automatic logic model_interrupt();
`ifdef COVERAGE_SUMMARY_EN
    longint unsigned lim;
    lim = MAX_WAIT * (longint'(cov) / 524288 + 1);
    return (m_stall >= lim) || (m_wd >= WD_LIMIT);
`else
    return 1'b0;
`endif
  endfunction

  task automatic checkOutput();
    check("io_uart_tx", 64'(io_uart_tx), 64'd1);
    check("tohost", tohost, m_tohost);
    check("pass", 64'(pass), 64'(m_tohost[0]));
    check("timeout", 64'(timeout), 64'(m_timeout));
    check("cycle_count", cycle_count, m_cycle);
    check("enq_evt_valid", 64'(enq_evt_valid), 64'(m_enq_v));
    check("enq_evt_id", 64'(enq_evt_id), 64'(m_enq_id));
    check("cmt_evt_valid", 64'(cmt_evt_valid), 64'(m_cmt_v));
    check("cmt_evt_id", 64'(cmt_evt_id), 64'(m_cmt_id));
    check("interrupt", 64'(interrupt), 64'(model_interrupt()));
  endtask

  task automatic applyStimulus(input int cycles);
    repeat (cycles) begin
      @(posedge clock);
      modelStep();
      #1;
      checkOutput();
    end
  endtask

  task automatic idleInputs();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    enq_valid = 1'b0; enq_inst = '0; commit_valid = 1'b0; commit_inst = '0;
  endtask

  task automatic doReset();
    reset = 1'b0;
    applyStimulus(1);
    reset = 1'b1;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] m;
    m = 32'h0000_2013 | (32'($urandom_range(0, 15)) << 20);
    case ($urandom_range(0, 3))
      0, 1: return m;
      2: return $urandom;
      default: return m ^ (32'd1 << $urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    vecs[0] = '{1'b1, 32'h00402013, 1'b0, 32'h00000000, 1'b1, 4'd4,  1'b0, 4'd0};
    vecs[1] = '{1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 4'd4,  1'b0, 4'd0};
    vecs[2] = '{1'b1, 32'h00002013, 1'b1, 32'h00d02013, 1'b1, 4'd0,  1'b1, 4'd13};
    vecs[3] = '{1'b1, 32'h00e02013, 1'b1, 32'h00e02013, 1'b0, 4'd0,  1'b0, 4'd13};
    vecs[4] = '{1'b0, 32'h00302013, 1'b1, 32'h00f02013, 1'b0, 4'd0,  1'b0, 4'd13};
    vecs[5] = '{1'b1, 32'h00502093, 1'b1, 32'h01202013, 1'b0, 4'd0,  1'b0, 4'd13};
    vecs[6] = '{1'b1, 32'h00b02013, 1'b1, 32'h00702013, 1'b1, 4'd11, 1'b1, 4'd7};
    vecs[7] = '{1'b1, 32'h00102013, 1'b0, 32'h00802013, 1'b1, 4'd1,  1'b0, 4'd7};

    idleInputs();
    cov = '0; io_uart_rx = 1'b0;
    reset = 1'b0; to_reset = 1'b0;
    applyStimulus(2);
    check("reset_tohost", tohost, 64'd0);
    check("reset_cycle_count", cycle_count, 64'd0);
    reset = 1'b1;

    // Marker decode vectors
    for (int i = 0; i < 8; i++) begin
      enq_valid = vecs[i].enq_valid;  enq_inst = vecs[i].enq_inst;
      commit_valid = vecs[i].commit_valid; commit_inst = vecs[i].commit_inst;
      applyStimulus(1);
      check($sformatf("vec%0d_enq_v", i), 64'(enq_evt_valid), 64'(vecs[i].exp_enq_v));
      check($sformatf("vec%0d_enq_id", i), 64'(enq_evt_id), 64'(vecs[i].exp_enq_id));
      check($sformatf("vec%0d_cmt_v", i), 64'(cmt_evt_valid), 64'(vecs[i].exp_cmt_v));
      check($sformatf("vec%0d_cmt_id", i), 64'(cmt_evt_id), 64'(vecs[i].exp_cmt_id));
    end
    idleInputs();

    // tohost: wrong address ignored, pass at cycle 100 ends the round
    doReset();
    wr_en = 1'b1; wr_addr = TOHOST_ADDR + 32'd8; wr_data = 64'hdead_beef;
    applyStimulus(1);
    check("wrong_addr_tohost", tohost, 64'd0);
    idleInputs();
    applyStimulus(99);
    check("pre_pass_cycle_count", cycle_count, 64'd100);
    wr_en = 1'b1; wr_addr = TOHOST_ADDR; wr_data = 64'd1;
    applyStimulus(1);
    check("pass_set", 64'(pass), 64'd1);
    idleInputs();
    applyStimulus(1);
    check("round_end_count", cycle_count, 64'd0);
    wr_en = 1'b1; wr_addr = TOHOST_ADDR; wr_data = 64'd0;
    applyStimulus(1);
    idleInputs();
    applyStimulus(3);

    // Timeout on the small-threshold instance
    to_reset = 1'b0;
    applyStimulus(1);
    to_reset = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      applyStimulus(1);
      check($sformatf("to_count_e%0d", e), to_cycle_count, (e <= 11) ? 64'(e) : 64'd0);
      check($sformatf("to_pulse_e%0d", e), 64'(to_timeout), (e == 12) ? 64'd1 : 64'd0);
      check($sformatf("to_tohost_e%0d", e), to_tohost, (e >= 12) ? 64'd5 : 64'd0);
    end
    check("to_pass", 64'(to_pass), 64'd1);
    check("to_uart_tx", 64'(to_uart_tx), 64'd1);
    check("to_events", 64'({to_enq_v, to_cmt_v, to_interrupt}), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) != 0);
      enq_valid = $urandom_range(0, 1) == 1;  enq_inst = rand_inst();
      commit_valid = $urandom_range(0, 1) == 1; commit_inst = rand_inst();
      wr_en = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 2))
        0: wr_addr = TOHOST_ADDR;
        1: wr_addr = TOHOST_ADDR + 32'd8;
        default: wr_addr = $urandom;
      endcase
      wr_data = {$urandom, $urandom};
      if ($urandom_range(0, 19) == 0) cov = 30'($urandom);
      io_uart_rx = $urandom_range(0, 1) == 1;
      applyStimulus(1);
    end
    reset = 1'b1;
    idleInputs();

    // Reset mid-run with tohost=5, pending events and nonzero counters
    wr_en = 1'b1; wr_addr = TOHOST_ADDR; wr_data = 64'd0;
    applyStimulus(2);
    idleInputs();
    applyStimulus(3);
    wr_en = 1'b1; wr_addr = TOHOST_ADDR; wr_data = 64'd5;
    enq_valid = 1'b1; enq_inst = 32'h00402013; commit_valid = 1'b1; commit_inst = 32'h00d02013;
    applyStimulus(1);
    check("pre_reset_tohost", tohost, 64'd5);
    check("pre_reset_events", 64'({enq_evt_valid, cmt_evt_valid}), 64'd3);
    reset = 1'b0; to_reset = 1'b0;
    applyStimulus(1);
    check("mid_reset_outputs", 64'({pass, timeout, enq_evt_valid, cmt_evt_valid, interrupt}), 64'd0);
    check("mid_reset_ids", 64'({enq_evt_id, cmt_evt_id}), 64'd0);
    check("mid_reset_tohost", tohost, 64'd0);
    check("mid_reset_count", cycle_count, 64'd0);
    check("mid_reset_uart", 64'(io_uart_tx), 64'd1);
    check("to_mid_reset", 64'({to_timeout, to_pass}) | to_tohost, 64'd0);
    reset = 1'b1; to_reset = 1'b1;
    idleInputs();

    // Coverage stall with constant cov=0: threshold 1000
    cov = '0;
    doReset();
    for (int n = 1; n <= 1001; n++) begin
      applyStimulus(1);
      if (n == 999) check("stall0_before", 64'(interrupt), 64'd0);
      if (n == 1000) check("stall0_at", 64'(interrupt), 64'(COV_EN));
    end

    // Coverage stall with cov=0x80000: threshold 2000, first edge sees a change
    cov = 30'h80000;
    doReset();
    for (int n = 1; n <= 2002; n++) begin
      applyStimulus(1);
      if (n == 2000) check("stall1_before", 64'(interrupt), 64'd0);
      if (n == 2001) check("stall1_at", 64'(interrupt), 64'(COV_EN));
    end

`ifdef COVERAGE_SUMMARY_EN
    // Watchdog with coverage changing every cycle
    cov = '0;
    doReset();
    for (int n = 1; n <= 50001; n++) begin
      cov = 30'(n);
      applyStimulus(1);
      if (n == 49999) check("watchdog_before", 64'(interrupt), 64'd0);
      if (n == 50000) check("watchdog_at", 64'(interrupt), 64'd1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
